// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: condition codes,
// flag bit positions and the flag-write request encoding.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Bit positions inside flag_w_i: upper bit requests N,Z, lower bit C,V.
    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Purely combinational decoder: does the 4-bit condition pass against
// the given {N,Z,C,V} flags.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        pass_o = 1'b0;
        case (cond_e'(cond_i))
            COND_EQ: pass_o = z;
            COND_NE: pass_o = !z;
            COND_CS: pass_o = c;
            COND_CC: pass_o = !c;
            COND_MI: pass_o = n;
            COND_PL: pass_o = !n;
            COND_VS: pass_o = v;
            COND_VC: pass_o = !v;
            COND_HI: pass_o = c && !z;
            COND_LS: pass_o = !c || z;
            COND_GE: pass_o = (n == v);
            COND_LT: pass_o = (n != v);
            COND_GT: pass_o = !z && (n == v);
            COND_LE: pass_o = z || (n != v);
            COND_AL: pass_o = 1'b1;
            COND_NV: pass_o = 1'b0;
            default: pass_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Condition-qualified control gating with a registered flag file.
// Performance counters are built only when COND_PERF_CNT_EN is defined.
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [3:0]       cond_i,
    input  logic [1:0]       flag_w_i,
    input  logic [3:0]       alu_flags_i,
    input  logic             pcs_i,
    input  logic             reg_w_i,
    input  logic             mem_w_i,
    output logic             pcsrc_o,
    output logic             regwrite_o,
    output logic             memwrite_o,
    output logic             cond_ex_o,
    output logic [3:0]       flags_o,
    output logic [CNT_W-1:0] exec_cnt_o,
    output logic [CNT_W-1:0] squash_cnt_o
);

    logic [3:0] flags_q, flags_d;
    logic       cond_pass;

    // Condition is judged against the registered flags, so an instruction
    // never sees flags produced by its own ALU result.
    cond_check u_cond_check (
        .cond_i  (cond_i),
        .flags_i (flags_q),
        .pass_o  (cond_pass)
    );

    assign cond_ex_o  = valid_i & cond_pass;
    assign pcsrc_o    = pcs_i & cond_ex_o;
    assign regwrite_o = reg_w_i & cond_ex_o;
    assign memwrite_o = mem_w_i & cond_ex_o;
    assign flags_o    = flags_q;

    always_comb begin
        flags_d = flags_q;
        if (cond_ex_o && flag_w_i[FW_NZ]) begin
            flags_d[FLAG_N] = alu_flags_i[FLAG_N];
            flags_d[FLAG_Z] = alu_flags_i[FLAG_Z];
        end
        if (cond_ex_o && flag_w_i[FW_CV]) begin
            flags_d[FLAG_C] = alu_flags_i[FLAG_C];
            flags_d[FLAG_V] = alu_flags_i[FLAG_V];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef COND_PERF_CNT_EN
    logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
    logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

    // Both counters stick at all-ones rather than wrapping.
    always_comb begin
        exec_cnt_d   = exec_cnt_q;
        squash_cnt_d = squash_cnt_q;
        if (cond_ex_o && (exec_cnt_q != '1)) begin
            exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end
        if (valid_i && !cond_ex_o && (squash_cnt_q != '1)) begin
            squash_cnt_d = squash_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exec_cnt_q   <= '0;
            squash_cnt_q <= '0;
        end else begin
            exec_cnt_q   <= exec_cnt_d;
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign exec_cnt_o   = exec_cnt_q;
    assign squash_cnt_o = squash_cnt_q;
`else
    assign exec_cnt_o   = '0;
    assign squash_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cond_unit.sv
// Table-driven bench for cond_unit; counter expectations follow
// whether COND_PERF_CNT_EN is defined for the build.
module tb_cond_unit;

    localparam int CW = 4;
`ifdef COND_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_i;
    logic [3:0]    cond_i;
    logic [1:0]    flag_w_i;
    logic [3:0]    alu_flags_i;
    logic          pcs_i, reg_w_i, mem_w_i;
    logic          pcsrc_o, regwrite_o, memwrite_o, cond_ex_o;
    logic [3:0]    flags_o;
    logic [CW-1:0] exec_cnt_o, squash_cnt_o;

    int checks = 0;
    int failures = 0;
    int modelExec = 0;
    int modelSquash = 0;

    typedef struct packed {
        logic       rst;
        logic       valid;
        logic [3:0] cond;
        logic [1:0] fw;
        logic [3:0] alu;
        logic       pcs;
        logic       regw;
        logic       memw;
        logic       expEx;
        logic [3:0] expFlags;
    } vec_t;

    vec_t vecs[$];

    cond_unit #(.CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .cond_i       (cond_i),
        .flag_w_i     (flag_w_i),
        .alu_flags_i  (alu_flags_i),
        .pcs_i        (pcs_i),
        .reg_w_i      (reg_w_i),
        .mem_w_i      (mem_w_i),
        .pcsrc_o      (pcsrc_o),
        .regwrite_o   (regwrite_o),
        .memwrite_o   (memwrite_o),
        .cond_ex_o    (cond_ex_o),
        .flags_o      (flags_o),
        .exec_cnt_o   (exec_cnt_o),
        .squash_cnt_o (squash_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic addVec(input logic r, input logic v, input logic [3:0] c,
                          input logic [1:0] fw, input logic [3:0] alu,
                          input logic pcs, input logic rw, input logic mw,
                          input logic ex, input logic [3:0] fl);
        vec_t t;
        t.rst = r; t.valid = v; t.cond = c; t.fw = fw; t.alu = alu;
        t.pcs = pcs; t.regw = rw; t.memw = mw; t.expEx = ex; t.expFlags = fl;
        vecs.push_back(t);
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, idx, actual, expected);
        end
    endtask

    // Drive one vector, check combinational outputs, clock it, check state.
    task automatic applyStimulus(input vec_t t, input int idx);
        @(negedge clk);
        rst = t.rst; valid_i = t.valid; cond_i = t.cond; flag_w_i = t.fw;
        alu_flags_i = t.alu; pcs_i = t.pcs; reg_w_i = t.regw; mem_w_i = t.memw;
        #1;
        checkOutput("cond_ex", idx, 32'(cond_ex_o), 32'(t.expEx));
        checkOutput("pcsrc", idx, 32'(pcsrc_o), 32'(t.pcs & t.expEx));
        checkOutput("regwrite", idx, 32'(regwrite_o), 32'(t.regw & t.expEx));
        checkOutput("memwrite", idx, 32'(memwrite_o), 32'(t.memw & t.expEx));
        if (t.rst) begin
            modelExec = 0;
            modelSquash = 0;
        end else if (t.valid && t.expEx) begin
            if (modelExec < CNT_MAX) modelExec++;
        end else if (t.valid) begin
            if (modelSquash < CNT_MAX) modelSquash++;
        end
        @(posedge clk);
        #1;
        checkOutput("flags", idx, 32'(flags_o), 32'(t.expFlags));
        checkOutput("exec_cnt", idx, 32'(exec_cnt_o), PERF ? 32'(modelExec) : 32'd0);
        checkOutput("squash_cnt", idx, 32'(squash_cnt_o), PERF ? 32'(modelSquash) : 32'd0);
    endtask

    initial begin
        rst = 1'b1; valid_i = 1'b0; cond_i = 4'h0; flag_w_i = 2'b00;
        alu_flags_i = 4'h0; pcs_i = 1'b0; reg_w_i = 1'b0; mem_w_i = 1'b0;

        //     rst valid cond     fw     alu      pcs  rw   mw   ex   flags
        addVec(1, 1, 4'b0001, 2'b11, 4'b1111, 0, 1, 0, 1, 4'b0000); // NE executes in reset, write ignored
        addVec(0, 1, 4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000); // EQ squashed, squash=1
        addVec(0, 1, 4'b1110, 2'b11, 4'b0100, 0, 0, 0, 1, 4'b0100); // AL captures Z
        addVec(0, 1, 4'b0000, 2'b00, 4'b0000, 0, 1, 0, 1, 4'b0100); // EQ now passes
        addVec(0, 1, 4'b0001, 2'b11, 4'b1111, 1, 0, 1, 0, 4'b0100); // NE squashed, flags held
        addVec(0, 0, 4'b1110, 2'b11, 4'b1111, 1, 1, 1, 0, 4'b0100); // invalid, flags held
        addVec(1, 0, 4'b1110, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000); // mid-sequence reset
        addVec(0, 1, 4'b1110, 2'b01, 4'b1111, 0, 0, 0, 1, 4'b0011); // C,V only
        addVec(0, 1, 4'b1110, 2'b11, 4'b1000, 0, 0, 0, 1, 4'b1000); // N=1 V=0
        addVec(0, 1, 4'b1010, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b1000); // GE fails
        addVec(0, 1, 4'b1011, 2'b00, 4'b0000, 0, 1, 0, 1, 4'b1000); // LT passes
        addVec(0, 1, 4'b1110, 2'b11, 4'b1001, 0, 0, 0, 1, 4'b1001); // N=1 V=1 Z=0
        addVec(0, 1, 4'b1100, 2'b00, 4'b0000, 1, 0, 0, 1, 4'b1001); // GT passes
        addVec(0, 1, 4'b1111, 2'b11, 4'b0000, 1, 1, 1, 0, 4'b1001); // never
        addVec(0, 1, 4'b1000, 2'b00, 4'b0000, 1, 0, 0, 0, 4'b1001); // HI fails, C=0
        addVec(0, 1, 4'b1001, 2'b00, 4'b0000, 1, 0, 0, 1, 4'b1001); // LS passes
        addVec(0, 1, 4'b1110, 2'b10, 4'b0110, 0, 0, 0, 1, 4'b0101); // N,Z only
        addVec(0, 1, 4'b0000, 2'b11, 4'b0000, 0, 0, 0, 1, 4'b0000); // EQ sees old Z=1
        addVec(0, 1, 4'b0000, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000); // new Z=0 one cycle later
        addVec(0, 1, 4'b0100, 2'b00, 4'b0000, 0, 0, 0, 0, 4'b0000); // MI fails
        addVec(0, 1, 4'b0111, 2'b00, 4'b0000, 0, 0, 1, 1, 4'b0000); // VC passes

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Saturation: reset, then 20 always-executing cycles.
        applyStimulus(vec_t'{rst: 1'b1, valid: 1'b0, cond: 4'b1110, fw: 2'b00, alu: 4'b0000,
                             pcs: 1'b0, regw: 1'b0, memw: 1'b0, expEx: 1'b0, expFlags: 4'b0000}, 100);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(vec_t'{rst: 1'b0, valid: 1'b1, cond: 4'b1110, fw: 2'b00, alu: 4'b0000,
                                 pcs: 1'b0, regw: 1'b1, memw: 1'b0, expEx: 1'b1, expFlags: 4'b0000},
                          101 + i);
        end
        checkOutput("exec_sat", 200, 32'(exec_cnt_o), PERF ? 32'd15 : 32'd0);
        checkOutput("squash_after_sat", 201, 32'(squash_cnt_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 SHALL have parameter CNT_W, default 32, the width of each performance counter.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port valid_i  in  1  instruction present this cycle.
REQ-005 SHALL have port cond_i  in  4  instruction condition field.
REQ-006 SHALL have port flag_w_i  in  2  flag write request: [1] updates N,Z; [0] updates C,V.
REQ-007 SHALL have port alu_flags_i  in  4  {N,Z,C,V} from the ALU for the current instruction.
REQ-008 SHALL have ports pcs_i, reg_w_i, mem_w_i  in  1 each  decoder-requested PC redirect, register write and memory write.
REQ-009 SHALL have ports pcsrc_o, regwrite_o, memwrite_o  out  1 each  condition-qualified controls.
REQ-010 SHALL have port cond_ex_o  out  1  current instruction executes.
REQ-011 SHALL have port flags_o  out  4  registered {N,Z,C,V}.
REQ-012 SHALL have ports exec_cnt_o, squash_cnt_o  out  CNT_W each  executed and squashed instruction counts.

Function
REQ-013 SHALL evaluate cond_i combinationally against registered flags_o, not alu_flags_i.
REQ-014 SHALL decode: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL true; 1111 never, false.
REQ-015 SHALL drive cond_ex_o = valid_i & condition result; 0 when valid_i=0.
REQ-016 SHALL drive pcsrc_o = pcs_i & cond_ex_o, regwrite_o = reg_w_i & cond_ex_o, memwrite_o = mem_w_i & cond_ex_o, with zero latency.
REQ-017 SHALL update N,Z from alu_flags_i at the next edge only when cond_ex_o & flag_w_i[1]; C,V only when cond_ex_o & flag_w_i[0]; the two halves independently.
REQ-018 SHALL hold flags when the instruction is squashed, invalid, or flag_w_i=00.
REQ-019 SHALL make new flags visible to the instruction in the following cycle (one-cycle flag latency), never the same cycle.
REQ-020 SHALL increment exec_cnt_o on each cycle with cond_ex_o=1 and squash_cnt_o on each cycle with valid_i=1 & cond_ex_o=0.
REQ-021 SHALL saturate each counter at all-ones; no wrap-around.

Reset
REQ-022 SHALL on rst=1 at a clock edge set flags_o=0000 and both counters to 0; rst overrides any simultaneous flag write or count.
REQ-023 SHALL keep combinational outputs evaluated during reset; with flags 0000, EQ squashes and NE executes.
REQ-024 SHALL resume normal updates at the first edge with rst=0; reset mid-sequence discards prior flags.

Configuration
REQ-025 SHALL use macro COND_PERF_CNT_EN: when defined, counters per REQ-020/021; when undefined, no counter registers are built and exec_cnt_o, squash_cnt_o are tied to 0.

Structure
REQ-026 SHALL take the 4-bit condition code constants, flag bit index constants (N=3,Z=2,C=1,V=0) and the flag-write encoding from the shared package cond_pkg.
REQ-027 SHALL place condition decoding in combinational sub-module cond_check (inputs cond, flags; output pass); flag register, gating and counters stay in cond_unit.

Verification
REQ-028 SHALL cover reset: rst=1 one edge -> flags_o=0000, counters 0; cond_i=0000 valid -> cond_ex_o=0, squash_cnt_o=1 next cycle.
REQ-029 SHALL cover flag capture: AL, flag_w_i=11, alu_flags_i=0100 -> flags_o=0100 next cycle; then EQ with reg_w_i=1 -> regwrite_o=1.
REQ-030 SHALL cover split write: flags 0000, AL, flag_w_i=01, alu_flags_i=1111 -> flags_o=0011; N,Z unchanged.
REQ-031 SHALL cover squash: flags 0100, cond_i=0001 NE, flag_w_i=11, mem_w_i=1, pcs_i=1 -> memwrite_o=0, pcsrc_o=0, flags unchanged.
REQ-032 SHALL cover signed conditions: flags N=1,V=0 -> GE fail, LT pass; flags N=1,V=1,Z=0 -> GT pass; cond 1111 always fails.
REQ-033 SHALL cover saturation with CNT_W=4 and COND_PERF_CNT_EN defined: 20 AL cycles -> exec_cnt_o=15; without the macro both counters read 0.
